elastic_pipeline_register: RTL and testbench

// - Parametrised successor of the plain enable-gated pipeline register: a chain
//   of DEPTH ready/valid register slices, each with a one-entry skid buffer.
// - Full throughput: one word per cycle. Backpressure is fully registered, with
//   no combinational ready path from out_ready to in_ready.
// - Used between processor/vector pipeline stages that stall independently.
// - Provides synchronous flush (branch/exception squash) and an occupancy count.
//

---
 rtl/elastic_pipeline_register.sv | 167 ++++++++++++++++
 tb/tb_elastic_pipeline_register.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipeline_register.sv
// elastic_pipeline_register
// Chain of DEPTH ready/valid register slices, each holding a main entry and a
// one-entry skid buffer. Upstream ready of every slice is taken from its
// registered skid-valid bit, so there is no combinational path from out_ready
// to in_ready while full throughput (one word per cycle) is kept.
// A synchronous flush squashes every held word; occupancy counts the words
// held across all slices (main + skid).

module elastic_pipeline_register #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 1,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  localparam int OCC_W        = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  // Per-slice state: main entry feeds the downstream side, skid catches the
  // word that arrives in the cycle the downstream side first stalls.
  logic [DEPTH-1:0] main_vld_q, main_vld_d;
  logic [DEPTH-1:0] skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] main_dat_q [DEPTH];
  logic [WIDTH-1:0] main_dat_d [DEPTH];
  logic [WIDTH-1:0] skid_dat_q [DEPTH];
  logic [WIDTH-1:0] skid_dat_d [DEPTH];

  // Slice-to-slice wiring: slice k's downstream side is slice k+1's upstream.
  logic [DEPTH-1:0] up_vld;
  logic [WIDTH-1:0] up_dat [DEPTH];
  logic [DEPTH-1:0] dn_rdy;
  logic [DEPTH-1:0] accept;
  logic [DEPTH-1:0] drain;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_hs;
  logic             out_hs;

  for (genvar k = 0; k < DEPTH; k++) begin : g_link
    if (k == 0) begin : g_head
      assign up_vld[k] = in_valid;
      assign up_dat[k] = in_data;
    end else begin : g_mid_up
      assign up_vld[k] = main_vld_q[k-1];
      assign up_dat[k] = main_dat_q[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign dn_rdy[k] = out_ready;
    end else begin : g_mid_dn
      assign dn_rdy[k] = ~skid_vld_q[k+1];
    end

    // A slice takes a word whenever its skid is free; it hands one on when
    // its main entry is valid and the next stage is ready.
    assign accept[k] = up_vld[k] & ~skid_vld_q[k];
    assign drain[k]  = main_vld_q[k] & dn_rdy[k];
  end

  // Next-state of every slice; flush overrides any transfer in that cycle.
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_dat_d = main_dat_q;
    skid_dat_d = skid_dat_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        main_vld_d[k] = 1'b0;
        skid_vld_d[k] = 1'b0;
        if (ZERO_ON_FLUSH) begin
          main_dat_d[k] = '0;
          skid_dat_d[k] = '0;
        end
      end else if (drain[k]) begin
        if (skid_vld_q[k]) begin
          // Skid word moves forward; accept is impossible while skid is full.
          main_dat_d[k] = skid_dat_q[k];
          skid_vld_d[k] = 1'b0;
        end else if (accept[k]) begin
          // Pass-through: drain and refill on the same edge, no bubble.
          main_dat_d[k] = up_dat[k];
        end else begin
          main_vld_d[k] = 1'b0;
        end
      end else if (accept[k]) begin
        if (!main_vld_q[k]) begin
          main_vld_d[k] = 1'b1;
          main_dat_d[k] = up_dat[k];
        end else begin
          // Main is stalled downstream: park the word in the skid.
          skid_vld_d[k] = 1'b1;
          skid_dat_d[k] = up_dat[k];
        end
      end
    end
  end

  // Valid bits of all slices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_vld_q <= '0;
      skid_vld_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  if (ZERO_ON_FLUSH) begin : g_dat_rst
    // Payload registers, cleared by reset so idle outputs read as zero.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < DEPTH; k++) begin
          main_dat_q[k] <= '0;
          skid_dat_q[k] <= '0;
        end
      end else begin
        main_dat_q <= main_dat_d;
        skid_dat_q <= skid_dat_d;
      end
    end
  end else begin : g_dat_norst
    // Payload registers without reset; only valid bits carry meaning.
    always_ff @(posedge clk) begin
      main_dat_q <= main_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Word count across the chain: external handshakes only, internal moves net 0.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_hs && !out_hs) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (out_hs && !in_hs) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign in_ready  = ~skid_vld_q[0];
  assign out_valid = main_vld_q[DEPTH-1];
  assign out_data  = main_dat_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Directed bench for elastic_pipeline_register: three instances (DEPTH 1, 2, 3)
// share clock, reset and flush and are exercised one at a time.

module tb_elastic_pipeline_register;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  logic        iv1 = 0, ir1, ov1, or1 = 0;
  logic [31:0] id1 = 0, od1;
  logic [1:0]  occ1;
  logic        iv2 = 0, ir2, ov2, or2 = 0;
  logic [31:0] id2 = 0, od2;
  logic [2:0]  occ2;
  logic        iv3 = 0, ir3, ov3, or3 = 0;
  logic [31:0] id3 = 0, od3;
  logic [2:0]  occ3;

  int errors = 0;
  int checks = 0;
  logic [31:0] sbq [$];
  logic [31:0] cur;
  logic [31:0] front;
  bit pend;
  bit tog;
  int sent;
  int cyc;

  elastic_pipeline_register #(.WIDTH(32), .DEPTH(1), .ZERO_ON_FLUSH(1'b1)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1));

  elastic_pipeline_register #(.WIDTH(32), .DEPTH(2), .ZERO_ON_FLUSH(1'b1)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(occ2));

  elastic_pipeline_register #(.WIDTH(32), .DEPTH(3), .ZERO_ON_FLUSH(1'b1)) u_d3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(occ3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state ----
    #12;
    chk("rst_ov1", ov1, 0); chk("rst_od1", od1, 0); chk("rst_occ1", occ1, 0);
    chk("rst_ov3", ov3, 0); chk("rst_occ3", occ3, 0);
    #10 reset = 1'b1;
    step();
    chk("rel_ir1", ir1, 1); chk("rel_ir2", ir2, 1); chk("rel_ir3", ir3, 1);
    chk("rel_ov2", ov2, 0); chk("rel_od2", od2, 0);

    // ---- 1: DEPTH=1 streaming, one word per cycle ----
    iv1 = 1; or1 = 1; id1 = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t1_ov", ov1, 1);
      chk("t1_od", od1, i);
      chk("t1_occ", occ1, 1);
      chk("t1_ir", ir1, 1);
      id1 = i + 1;
    end
    iv1 = 0;
    step();
    chk("t1_end_ov", ov1, 0); chk("t1_end_occ", occ1, 0);

    // ---- 2: DEPTH=2 fill under backpressure, then drain in order ----
    iv2 = 1; or2 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_ir_open", ir2, 1);
      id2 = 32'hA + i;
      step();
    end
    chk("t2_ir_full", ir2, 0); chk("t2_occ_full", occ2, 4);
    chk("t2_ov", ov2, 1); chk("t2_od_head", od2, 32'hA);
    id2 = 32'hE;
    step();
    chk("t2_hold_occ", occ2, 4); chk("t2_hold_od", od2, 32'hA);
    iv2 = 0; or2 = 1;
    for (int j = 0; j < 4; j++) begin
      chk("t2_drain_ov", ov2, 1);
      chk("t2_drain_od", od2, 32'hA + j);
      step();
    end
    chk("t2_empty_ov", ov2, 0); chk("t2_empty_occ", occ2, 0);
    chk("t2_empty_ir", ir2, 1);

    // ---- 6: DEPTH=2 output held stable under backpressure ----
    or2 = 0; iv2 = 1; id2 = 32'h3C;
    step();
    iv2 = 0; id2 = 32'h0;
    chk("t6_lat_ov", ov2, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t6_ov", ov2, 1); chk("t6_od", od2, 32'h3C); chk("t6_occ", occ2, 1);
      step();
    end
    or2 = 1;
    step();
    chk("t6_done_ov", ov2, 0); chk("t6_done_occ", occ2, 0);
    or2 = 0;

    // ---- 3: DEPTH=3 fill, then toggled out_ready with scoreboard ----
    pend = 0; tog = 0; sent = 0; cyc = 0;
    or3 = 0;
    while (ir3 && cyc < 20) begin
      if (!pend) begin cur = $urandom; pend = 1; end
      iv3 = 1; id3 = cur;
      chk("t3_fill_occ", occ3, sbq.size());
      if (iv3 && ir3) begin sbq.push_back(cur); pend = 0; sent++; end
      step();
      cyc++;
    end
    chk("t3_full_ir", ir3, 0); chk("t3_full_occ", occ3, 6);
    cyc = 0;
    while (sent < 1000 && cyc < 5000) begin
      if (!pend) begin cur = $urandom; pend = 1; end
      iv3 = 1; id3 = cur; or3 = tog;
      chk("t3_occ", occ3, sbq.size());
      if (ov3 && or3) begin
        if (sbq.size() == 0) chk("t3_extra", ov3, 0);
        else begin front = sbq.pop_front(); chk("t3_word", od3, front); end
      end
      if (iv3 && ir3) begin sbq.push_back(cur); pend = 0; sent++; end
      step();
      tog = ~tog; cyc++;
    end
    chk("t3_sent", sent, 1000);
    iv3 = 0; or3 = 1; cyc = 0;
    while (sbq.size() > 0 && cyc < 50) begin
      if (ov3) begin front = sbq.pop_front(); chk("t3_drain_word", od3, front); end
      step();
      cyc++;
    end
    chk("t3_left", sbq.size(), 0);
    chk("t3_end_ov", ov3, 0); chk("t3_end_occ", occ3, 0);

    // ---- 4: flush with occupancy 3 and both handshakes offered ----
    or3 = 0; iv3 = 1;
    for (int i = 1; i <= 3; i++) begin
      id3 = 32'h11 * i;
      step();
    end
    chk("t4_pre_occ", occ3, 3);
    flush = 1; iv3 = 1; id3 = 32'h44; or3 = 1;
    step();
    flush = 0; iv3 = 0;
    chk("t4_ov", ov3, 0); chk("t4_occ", occ3, 0); chk("t4_ir", ir3, 1);
    chk("t4_od_zero", od3, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t4_no_ghost", ov3, 0);
      step();
    end
    iv3 = 1; id3 = 32'h55;
    step();
    iv3 = 0;
    chk("t4_lat0", ov3, 0);
    step();
    chk("t4_lat1", ov3, 0);
    step();
    chk("t4_new_ov", ov3, 1); chk("t4_new_od", od3, 32'h55);
    step();
    chk("t4_new_gone", ov3, 0); chk("t4_new_occ", occ3, 0);
    or3 = 0;

    // ---- 5: asynchronous reset mid-stream on DEPTH=1 ----
    iv1 = 1; or1 = 1;
    for (int i = 0; i < 3; i++) begin
      id1 = 32'h100 + i;
      step();
    end
    chk("t5_pre_ov", ov1, 1);
    reset = 0;
    #1;
    chk("t5_ov", ov1, 0); chk("t5_od", od1, 0); chk("t5_occ", occ1, 0);
    iv1 = 0;
    #3 reset = 1;
    step();
    chk("t5_rel_ir", ir1, 1); chk("t5_rel_ov", ov1, 0); chk("t5_rel_occ", occ1, 0);
    iv1 = 1; id1 = 32'h77;
    step();
    iv1 = 0;
    chk("t5_resume_ov", ov1, 1); chk("t5_resume_od", od1, 32'h77);
    chk("t5_resume_occ", occ1, 1);
    step();
    chk("t5_final_ov", ov1, 0); chk("t5_final_occ", occ1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
